// File: rtl/operand_fetch_stage.sv
// Operand-fetch stage: 16x16 register file, busy scoreboard and a registered valid/ready hand-off to the ALU.
// Optional build macro OPERAND_BYPASS_EN forwards same-cycle write-back data to the operand reads.
module operand_fetch_stage (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_opcode,
  input  logic [3:0]  in_rdest,
  input  logic [3:0]  in_rsrc,
  input  logic [7:0]  in_imm,
  input  logic        in_imm_sel,
  input  logic        in_wr_dest,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_r1,
  output logic [15:0] out_r2,
  output logic [7:0]  out_opcode,
  output logic [3:0]  out_rdest,
  input  logic        wb_en,
  input  logic [3:0]  wb_addr,
  input  logic [15:0] wb_data
);

  localparam int unsigned NREGS = 16;
  localparam int unsigned AW    = 4;
  localparam int unsigned DW    = 16;
  localparam int unsigned OPW   = 8;
  localparam int unsigned IMMW  = 8;

  logic [DW-1:0]    r_rf [NREGS];
  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_busy_nxt;

  logic             w_fwd_d;
  logic             w_fwd_s;
  logic             w_busy_d;
  logic             w_busy_s;
  logic             w_hazard;
  logic             w_accept;
  logic [DW-1:0]    w_imm_sext;
  logic [DW-1:0]    w_rd_d;
  logic [DW-1:0]    w_rd_s;
  logic [DW-1:0]    w_op2;

  // Write-back hitting a read index in the read cycle
`ifdef OPERAND_BYPASS_EN
  assign w_fwd_d = wb_en & (wb_addr == in_rdest);
  assign w_fwd_s = wb_en & (wb_addr == in_rsrc);
`else
  assign w_fwd_d = 1'b0;
  assign w_fwd_s = 1'b0;
`endif

  assign w_busy_d = r_busy[in_rdest] & ~w_fwd_d;
  assign w_busy_s = r_busy[in_rsrc]  & ~w_fwd_s;

  // rdest is checked even without a write so WAW and r1 RAW both stall
  assign w_hazard = w_busy_d | (~in_imm_sel & w_busy_s);
  assign in_ready = (~out_valid | out_ready) & ~w_hazard;
  assign w_accept = in_valid & in_ready;

  assign w_imm_sext = {{(DW-IMMW){in_imm[IMMW-1]}}, in_imm};
  assign w_rd_d     = w_fwd_d ? wb_data : r_rf[in_rdest];
  assign w_rd_s     = w_fwd_s ? wb_data : r_rf[in_rsrc];
  assign w_op2      = in_imm_sel ? w_imm_sext : w_rd_s;

  // Scoreboard update: write-back clears, a new pending write on the same edge wins
  always_comb begin
    w_busy_nxt = r_busy;
    if (wb_en) begin
      w_busy_nxt[wb_addr] = 1'b0;
    end
    if (w_accept && in_wr_dest) begin
      w_busy_nxt[in_rdest] = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) begin
        r_rf[i] <= '0;
      end
    end else if (wb_en) begin
      r_rf[wb_addr] <= wb_data;
    end
  end

  // Output stage: load on accept, drain on ready, otherwise hold
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid  <= 1'b0;
      out_r1     <= '0;
      out_r2     <= '0;
      out_opcode <= '0;
      out_rdest  <= '0;
    end else if (w_accept) begin
      out_valid  <= 1'b1;
      out_r1     <= w_rd_d;
      out_r2     <= w_op2;
      out_opcode <= OPW'(in_opcode);
      out_rdest  <= AW'(in_rdest);
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Bench for operand_fetch_stage: directed scenarios plus randomized traffic against an array/scoreboard model.
module tb_operand_fetch_stage;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready, in_imm_sel, in_wr_dest;
  logic [7:0]  in_opcode, in_imm;
  logic [3:0]  in_rdest, in_rsrc;
  logic        out_valid, out_ready;
  logic [15:0] out_r1, out_r2;
  logic [7:0]  out_opcode;
  logic [3:0]  out_rdest;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic [15:0] wb_data;

  operand_fetch_stage dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_rdest(in_rdest), .in_rsrc(in_rsrc), .in_imm(in_imm),
    .in_imm_sel(in_imm_sel), .in_wr_dest(in_wr_dest),
    .out_valid(out_valid), .out_ready(out_ready), .out_r1(out_r1),
    .out_r2(out_r2), .out_opcode(out_opcode), .out_rdest(out_rdest),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  always #5 clock = ~clock;

`ifdef OPERAND_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // Reference state
  logic [15:0] m_rf [16];
  bit          m_busy [16];
  bit          m_ov;
  logic [15:0] m_r1, m_r2;
  logic [7:0]  m_op;
  logic [3:0]  m_rd;

  int n_checks = 0;
  int n_fail   = 0;
  logic last_rdy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_rf[i] = '0;
      m_busy[i] = 0;
    end
    m_ov = 0; m_r1 = '0; m_r2 = '0; m_op = '0; m_rd = '0;
  endtask

  task automatic idle();
    in_valid = 0; in_opcode = '0; in_rdest = '0; in_rsrc = '0; in_imm = '0;
    in_imm_sel = 0; in_wr_dest = 0; out_ready = 1; wb_en = 0; wb_addr = '0; wb_data = '0;
  endtask

  task automatic issue(input logic [7:0] op, input logic [3:0] rd, input logic [3:0] rs,
                       input logic [7:0] imm, input logic isel, input logic wr);
    in_valid = 1; in_opcode = op; in_rdest = rd; in_rsrc = rs;
    in_imm = imm; in_imm_sel = isel; in_wr_dest = wr;
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge after checking outputs
  task automatic cycle();
    bit fd, fs, hz, rdy, acc;
    logic [15:0] v1, v2, simm;
    #1;
    fd = BYP && wb_en && (wb_addr == in_rdest);
    fs = BYP && wb_en && (wb_addr == in_rsrc);
    hz = (m_busy[in_rdest] && !fd) || (!in_imm_sel && m_busy[in_rsrc] && !fs);
    rdy = (!m_ov || out_ready) && !hz;
    acc = in_valid && rdy;
    chk("in_ready", 32'(in_ready), 32'(rdy));
    last_rdy = in_ready;
    v1 = fd ? wb_data : m_rf[in_rdest];
    simm = 16'(signed'(in_imm));
    v2 = in_imm_sel ? simm : (fs ? wb_data : m_rf[in_rsrc]);
    @(posedge clock);
    if (acc) begin
      m_ov = 1; m_r1 = v1; m_r2 = v2; m_op = in_opcode; m_rd = in_rdest;
    end else if (out_ready) begin
      m_ov = 0;
    end
    if (wb_en) begin
      m_rf[wb_addr] = wb_data;
      m_busy[wb_addr] = 0;
    end
    if (acc && in_wr_dest) m_busy[in_rdest] = 1;
    @(negedge clock);
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    chk("out_r1", 32'(out_r1), 32'(m_r1));
    chk("out_r2", 32'(out_r2), 32'(m_r2));
    chk("out_opcode", 32'(out_opcode), 32'(m_op));
    chk("out_rdest", 32'(out_rdest), 32'(m_rd));
  endtask

  task automatic rand_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      in_valid   = ($urandom_range(0, 9) < 7);
      in_opcode  = 8'($urandom);
      in_rdest   = 4'($urandom);
      in_rsrc    = 4'($urandom);
      in_imm     = 8'($urandom);
      in_imm_sel = 1'($urandom);
      in_wr_dest = ($urandom_range(0, 3) != 0);
      out_ready  = ($urandom_range(0, 9) < 7);
      wb_en      = 1'($urandom);
      wb_addr    = 4'($urandom);
      wb_data    = 16'($urandom);
      cycle();
    end
  endtask

  initial begin
    logic [15:0] hold_r2;
    idle();
    reset_n = 0;
    model_reset();
    repeat (2) @(negedge clock);
    reset_n = 1;
    @(negedge clock);
    chk("reset_out_valid", 32'(out_valid), 32'h0);

    // Basic register read
    wb_en = 1; wb_addr = 4'd1; wb_data = 16'd5; cycle();
    wb_addr = 4'd2; wb_data = 16'd7; cycle();
    wb_en = 0;
    issue(8'h05, 4'd1, 4'd2, 8'h00, 0, 0); cycle();
    chk("t2_r1", 32'(out_r1), 32'd5);
    chk("t2_r2", 32'(out_r2), 32'd7);
    chk("t2_op", 32'(out_opcode), 32'h05);
    chk("t2_valid", 32'(out_valid), 32'h1);

    // Immediate sign extension
    issue(8'h06, 4'd1, 4'd0, 8'hFE, 1, 0); cycle();
    chk("t3_neg", 32'(out_r2), 32'hFFFE);
    issue(8'h06, 4'd1, 4'd0, 8'h7F, 1, 0); cycle();
    chk("t3_pos", 32'(out_r2), 32'h007F);

    // RAW stall on R3
    issue(8'h01, 4'd3, 4'd0, 8'h00, 1, 1); cycle();
    issue(8'h02, 4'd3, 4'd0, 8'h00, 1, 0); cycle();
    chk("t4_stall", 32'(last_rdy), 32'h0);
    wb_en = 1; wb_addr = 4'd3; wb_data = 16'h0009; cycle();
`ifdef OPERAND_BYPASS_EN
    chk("t4_wb_issue", 32'(last_rdy), 32'h1);
`else
    chk("t4_wb_stall", 32'(last_rdy), 32'h0);
    wb_en = 0; cycle();
    chk("t4_late_issue", 32'(last_rdy), 32'h1);
`endif
    wb_en = 0;
    chk("t4_r1", 32'(out_r1), 32'h0009);
    chk("t4_op", 32'(out_opcode), 32'h02);

    // Backpressure
    issue(8'h11, 4'd6, 4'd0, 8'h22, 1, 0); cycle();
    hold_r2 = out_r2;
    chk("t5_first", 32'(hold_r2), 32'h0022);
    out_ready = 0;
    issue(8'h12, 4'd7, 4'd0, 8'h33, 1, 0);
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("t5_blocked", 32'(last_rdy), 32'h0);
      chk("t5_hold_r2", 32'(out_r2), 32'h0022);
      chk("t5_hold_op", 32'(out_opcode), 32'h11);
    end
    out_ready = 1; cycle();
    chk("t5_release", 32'(last_rdy), 32'h1);
    chk("t5_next_op", 32'(out_opcode), 32'h12);

    // Compare does not mark its destination busy
    issue(8'h0B, 4'd4, 4'd1, 8'h00, 0, 0); cycle();
    issue(8'h03, 4'd4, 4'd4, 8'h00, 0, 0); cycle();
    chk("t6_no_stall", 32'(last_rdy), 32'h1);
    chk("t6_op", 32'(out_opcode), 32'h03);

    rand_cycles(3000);

    // Reset mid-transfer
    issue(8'h44, 4'd9, 4'd0, 8'h01, 1, 0); out_ready = 0; wb_en = 0; cycle();
    idle();
    reset_n = 0;
    #1;
    model_reset();
    chk("t1_valid", 32'(out_valid), 32'h0);
    chk("t1_r1", 32'(out_r1), 32'h0);
    chk("t1_r2", 32'(out_r2), 32'h0);
    chk("t1_op", 32'(out_opcode), 32'h0);
    chk("t1_rd", 32'(out_rdest), 32'h0);
    @(negedge clock);
    reset_n = 1;
    issue(8'h05, 4'd1, 4'd2, 8'h00, 0, 0); cycle();
    chk("t1_ready", 32'(last_rdy), 32'h1);
    chk("t1_rf_r1", 32'(out_r1), 32'h0);
    chk("t1_rf_r2", 32'(out_r2), 32'h0);

    rand_cycles(1500);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
